memory_responder: RTL and testbench



---
 rtl/memory_responder.sv | 169 ++++++++++++++++
 tb/tb_memory_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Single-beat external memory model with a per-bank open-row latency model and traffic counters.
// Latency L = base(read/write) + row-miss penalty; one request in flight, no accept until two cycles after its mem_ready pulse.
module memory_responder #(
  parameter int    MEM_WORDS        = 4096,
  parameter int    READ_LATENCY     = 4,
  parameter int    WRITE_LATENCY    = 2,
  parameter int    ROW_MISS_PENALTY = 3,
  parameter int    ROW_BYTES        = 1024,
  parameter int    NUM_BANKS        = 8,
  parameter string INIT_FILE        = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_en,
  input  logic        mem_request_valid,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_row_hits
);

  localparam int WIDX_W  = $clog2(MEM_WORDS);
  localparam int ROW_LOG = $clog2(ROW_BYTES);
  localparam int ROW_W   = 32 - ROW_LOG;
  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int MAX_LAT = ((READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY)
                           + ROW_MISS_PENALTY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       reads_q, reads_d;
  logic [31:0]       writes_q, writes_d;
  logic [31:0]       hits_q, hits_d;
  logic [NUM_BANKS-1:0]            open_valid_q, open_valid_d;
  logic [NUM_BANKS-1:0][ROW_W-1:0] open_row_q, open_row_d;

  logic [31:0] mem_array [MEM_WORDS];
  logic        mem_we;

  logic [ROW_W-1:0]  req_row;
  logic [BANK_W-1:0] req_bank;
  logic              req_hit;
  logic [CNT_W-1:0]  req_lat;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^mem_address[1:0];

  always_comb begin
    req_row  = mem_address[31:ROW_LOG];
    req_bank = (NUM_BANKS > 1) ? req_row[BANK_W-1:0] : '0;
    req_hit  = open_valid_q[req_bank] && (open_row_q[req_bank] == req_row);
    req_lat  = mem_write_en ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);
    if (!req_hit) begin
      req_lat = req_lat + CNT_W'(ROW_MISS_PENALTY);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    widx_d       = widx_q;
    wdata_d      = wdata_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    reads_d      = reads_q;
    writes_d     = writes_q;
    hits_d       = hits_q;
    open_valid_d = open_valid_q;
    open_row_d   = open_row_q;
    mem_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_request_valid) begin
          state_d                = S_WAIT;
          we_d                   = mem_write_en;
          widx_d                 = mem_address[WIDX_W+1:2];
          wdata_d                = mem_write_data;
          cnt_d                  = req_lat - CNT_W'(1);
          open_valid_d[req_bank] = 1'b1;
          open_row_d[req_bank]   = req_row;
          if (req_hit) begin
            hits_d = hits_q + 32'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          if (we_q) begin
            mem_we   = 1'b1;
            rdata_d  = wdata_q;
            writes_d = writes_q + 32'd1;
          end else begin
            rdata_d = mem_array[widx_q];
            reads_d = reads_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Extra cycle keeps a still-held request from being re-accepted.
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      widx_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      reads_q      <= '0;
      writes_q     <= '0;
      hits_q       <= '0;
      open_valid_q <= '0;
      open_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      widx_q       <= widx_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      reads_q      <= reads_d;
      writes_q     <= writes_d;
      hits_q       <= hits_d;
      open_valid_q <= open_valid_d;
      open_row_q   <= open_row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[widx_q] <= wdata_q;
    end
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = ready_q;
  assign busy          = (state_q != S_IDLE);
  assign stat_reads    = reads_q;
  assign stat_writes   = writes_q;
  assign stat_row_hits = hits_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: latency, data, row-hit model, reset abort and held-valid behaviour.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_request_valid;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        busy;
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_row_hits;

  int n_checks = 0;
  int n_pass   = 0;

  memory_responder dut (
    .clk               (clk),
    .rst               (rst),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_write_en      (mem_write_en),
    .mem_request_valid (mem_request_valid),
    .mem_read_data     (mem_read_data),
    .mem_ready         (mem_ready),
    .busy              (busy),
    .stat_reads        (stat_reads),
    .stat_writes       (stat_writes),
    .stat_row_hits     (stat_row_hits)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Issues one request, returns observed latency (-1 on timeout) and response data.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        output int lat, output logic [31:0] data);
    @(negedge clk);
    mem_address       = addr;
    mem_write_data    = wdata;
    mem_write_en      = we;
    mem_request_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_in_wait", 32'(busy), 32'd1);
      if (mem_ready) begin
        lat = i - 1;
        break;
      end
    end
    mem_request_valid = 1'b0;
    data = mem_read_data;
    if (lat >= 0) begin
      @(negedge clk);
      check("ready_one_cycle", 32'(mem_ready), 32'd0);
      check("busy_after_resp", 32'(busy), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          lat;
    logic [31:0] data;
    int          reads;
    int          writes;
    int          hits;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } pre_t;

  vec_t vecs[12];
  pre_t pre[6];

  initial begin
    int          lat;
    logic [31:0] data;
    int          pulses;
    int          last;

    pre[0] = '{32'h0000_0100, 32'hDEAD_BEEF};
    pre[1] = '{32'h0000_0040, 32'h0BAD_F00D};
    pre[2] = '{32'h0000_2000, 32'h2000_2000};
    pre[3] = '{32'h0000_0000, 32'h00C0_FFEE};
    pre[4] = '{32'h0000_0400, 32'hCAFE_0400};
    pre[5] = '{32'h0000_0404, 32'hCAFE_0404};

    // addr, wdata, we, latency, data, reads, writes, row hits (cumulative after reset)
    vecs[0]  = '{32'h0000_0100, 32'h0,          1'b0, 7, 32'hDEAD_BEEF, 1,  0, 0};
    vecs[1]  = '{32'h0000_0104, 32'h1234_5678, 1'b1, 2, 32'h1234_5678, 1,  1, 1};
    vecs[2]  = '{32'h0000_0104, 32'h0,          1'b0, 4, 32'h1234_5678, 2,  1, 2};
    vecs[3]  = '{32'h0000_0040, 32'h0,          1'b0, 4, 32'h0BAD_F00D, 3,  1, 3};
    vecs[4]  = '{32'h0000_2000, 32'h0,          1'b0, 7, 32'h2000_2000, 4,  1, 3};
    vecs[5]  = '{32'h0000_0000, 32'h0,          1'b0, 7, 32'h00C0_FFEE, 5,  1, 3};
    vecs[6]  = '{32'h0000_0400, 32'h0,          1'b0, 7, 32'hCAFE_0400, 6,  1, 3};
    vecs[7]  = '{32'h0000_0404, 32'h0,          1'b0, 4, 32'hCAFE_0404, 7,  1, 4};
    vecs[8]  = '{32'h0000_4008, 32'h0000_00A5, 1'b1, 5, 32'h0000_00A5, 7,  2, 4};
    vecs[9]  = '{32'h0000_0008, 32'h0,          1'b0, 7, 32'h0000_00A5, 8,  2, 4};
    vecs[10] = '{32'h0000_2000, 32'h0,          1'b0, 7, 32'h2000_2000, 9,  2, 4};
    vecs[11] = '{32'h0000_2000, 32'h0,          1'b0, 4, 32'h2000_2000, 10, 2, 5};

    rst               = 1'b1;
    mem_address       = '0;
    mem_write_data    = '0;
    mem_write_en      = 1'b0;
    mem_request_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reads", stat_reads, 32'd0);
    check("rst_writes", stat_writes, 32'd0);
    check("rst_hits", stat_row_hits, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_req(pre[i].addr, pre[i].data, 1'b1, lat, data);
      check($sformatf("pre_echo_%0d", i), data, pre[i].data);
    end

    // Reset in the middle of a write: outputs clear at once, memory keeps old word.
    @(negedge clk);
    mem_address       = 32'h0000_0040;
    mem_write_data    = 32'h1111_1111;
    mem_write_en      = 1'b1;
    mem_request_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst               = 1'b1;
    mem_request_valid = 1'b0;
    #1;
    check("abort_ready", 32'(mem_ready), 32'd0);
    check("abort_rdata", mem_read_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_writes", stat_writes, 32'd0);
    check("abort_hits", stat_row_hits, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].addr, vecs[i].wdata, vecs[i].we, lat, data);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_data", i), data, vecs[i].data);
      check($sformatf("v%0d_reads", i), stat_reads, vecs[i].reads);
      check($sformatf("v%0d_writes", i), stat_writes, vecs[i].writes);
      check($sformatf("v%0d_hits", i), stat_row_hits, vecs[i].hits);
    end

    // Valid held across three responses: 0x100 misses once (bank 0 holds row 8), then hits.
    @(negedge clk);
    mem_address       = 32'h0000_0100;
    mem_write_en      = 1'b0;
    mem_request_valid = 1'b1;
    pulses = 0;
    last   = 0;
    for (int i = 0; i < 100 && pulses < 3; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        if (pulses > 0) check($sformatf("held_gap_%0d", pulses), i - last, 6);
        check($sformatf("held_data_%0d", pulses), mem_read_data, 32'hDEAD_BEEF);
        pulses++;
        last = i;
      end
    end
    mem_request_valid = 1'b0;
    check("held_pulses", pulses, 3);
    @(negedge clk);
    check("held_ready_low", 32'(mem_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("held_busy_idle", 32'(busy), 32'd0);
    check("held_reads", stat_reads, 32'd13);
    check("held_hits", stat_row_hits, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
